// File: rtl/program_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : program_sequencer
//  Description : Run controller for the vector CPU. Gates PC advance, stalls
//                on COM while a 4-phase req/ack handshake with the host
//                interpreter completes, halts on END, keeps saturating
//                instruction/cycle counters and a COM-timeout watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module program_sequencer #(
  parameter int C  = 32,    // counter width
  parameter int T  = 1024,  // handshake timeout in cycles
  parameter int TW = 11     // timeout counter width, 2^TW > T
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   Id,
  input  logic         com_ack,
  output logic         pc_en,
  output logic         busy,
  output logic         com_req,
  output logic         done,
  output logic         error,
  output logic [C-1:0] instr_count,
  output logic [C-1:0] cycle_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd1;
  localparam logic [2:0] S_COM_REQ = 3'd2;
  localparam logic [2:0] S_COM_REL = 3'd3;
  localparam logic [2:0] S_HALT    = 3'd4;
  localparam logic [2:0] S_ERR     = 3'd5;

  localparam logic [3:0]    ID_COM  = 4'b0001;
  localparam logic [3:0]    ID_END  = 4'b0010;
  localparam logic [C-1:0]  CNT_MAX = {C{1'b1}};
  localparam logic [TW-1:0] TO_LAST = TW'(T - 1);

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic [TW-1:0] r_timeout;
  logic          w_active;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; HALT and ERR are absorbing until reset.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_RUN;
      end
      S_RUN: begin
        if (Id == ID_COM)      w_next = S_COM_REQ;
        else if (Id == ID_END) w_next = S_HALT;
      end
      S_COM_REQ: begin
        if (com_ack)                  w_next = S_COM_REL;
        else if (r_timeout == TO_LAST) w_next = S_ERR;
      end
      S_COM_REL: begin
        if (!com_ack)                 w_next = S_RUN;
        else if (r_timeout == TO_LAST) w_next = S_ERR;
      end
      S_HALT:  w_next = S_HALT;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_IDLE;
    endcase
  end

  // Combinational outputs: PC enable only in RUN on a non-END instruction.
  always_comb begin
    pc_en    = (r_state == S_RUN) && (Id != ID_END);
    w_active = (r_state == S_RUN) || (r_state == S_COM_REQ) || (r_state == S_COM_REL);
    busy     = w_active;
  end

  // Registered handshake request, sticky flags, watchdog and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      com_req     <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      r_timeout   <= '0;
      instr_count <= '0;
      cycle_count <= '0;
    end else begin
      // Request is high exactly while the FSM sits in COM_REQ.
      com_req <= (w_next == S_COM_REQ);
      done    <= done  | (w_next == S_HALT);
      error   <= error | (w_next == S_ERR);

      // Watchdog restarts on every state change, so each handshake phase
      // gets its own full budget.
      if (w_next != r_state) begin
        r_timeout <= '0;
      end else if ((r_state == S_COM_REQ) || (r_state == S_COM_REL)) begin
        r_timeout <= r_timeout + TW'(1);
      end

      if ((r_state == S_IDLE) && start) begin
        instr_count <= '0;
        cycle_count <= '0;
      end else begin
        if (w_active && (cycle_count != CNT_MAX)) begin
          cycle_count <= cycle_count + C'(1);
        end
        if ((r_state == S_RUN) && (instr_count != CNT_MAX)) begin
          instr_count <= instr_count + C'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_program_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_program_sequencer
//  Description : Scoreboard bench for program_sequencer. A stimulus process
//                drives one input vector per cycle and queues the response a
//                cycle-level reference model predicts; a monitor compares
//                DUT outputs on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_program_sequencer;

  localparam int CW   = 4;
  localparam int TO   = 1024;
  localparam int TOW  = 11;
  localparam int CMAX = (1 << CW) - 1;

  // Reference model modes (the six architectural situations).
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_WHI  = 2;  // waiting for ack to rise
  localparam int M_WLO  = 3;  // waiting for ack to fall
  localparam int M_HALT = 4;
  localparam int M_ERR  = 5;

  logic          clk;
  logic          reset;
  logic          start;
  logic [3:0]    Id;
  logic          com_ack;
  logic          pc_en;
  logic          busy;
  logic          com_req;
  logic          done;
  logic          error;
  logic [CW-1:0] instr_count;
  logic [CW-1:0] cycle_count;

  program_sequencer #(.C(CW), .T(TO), .TW(TOW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .Id         (Id),
    .com_ack    (com_ack),
    .pc_en      (pc_en),
    .busy       (busy),
    .com_req    (com_req),
    .done       (done),
    .error      (error),
    .instr_count(instr_count),
    .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic pc_en;
    logic busy;
    logic com_req;
    logic done;
    logic error;
    int   instr;
    int   cyc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  int m_mode  = M_IDLE;
  int m_instr = 0;
  int m_cyc   = 0;
  int m_wait  = 0;

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // One clock of stimulus: drive inputs, predict outputs, advance model.
  task automatic cycle(input logic s, input logic [3:0] id, input logic a, input logic r);
    exp_t e;
    @(posedge clk);
    #1;
    start   = s;
    Id      = id;
    com_ack = a;
    reset   = r;
    e.pc_en   = (m_mode == M_RUN) && (id != 4'b0010);
    e.busy    = (m_mode == M_RUN) || (m_mode == M_WHI) || (m_mode == M_WLO);
    e.com_req = (m_mode == M_WHI);
    e.done    = (m_mode == M_HALT);
    e.error   = (m_mode == M_ERR);
    e.instr   = m_instr;
    e.cyc     = m_cyc;
    q.push_back(e);
    if (r) begin
      m_mode = M_IDLE; m_instr = 0; m_cyc = 0; m_wait = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (s) begin m_mode = M_RUN; m_instr = 0; m_cyc = 0; end
        M_RUN: begin
          m_instr = sat(m_instr + 1);
          m_cyc   = sat(m_cyc + 1);
          if (id == 4'b0001) begin m_mode = M_WHI; m_wait = 0; end
          else if (id == 4'b0010) m_mode = M_HALT;
        end
        M_WHI: begin
          m_cyc  = sat(m_cyc + 1);
          m_wait = m_wait + 1;
          if (a) begin m_mode = M_WLO; m_wait = 0; end
          else if (m_wait == TO) m_mode = M_ERR;
        end
        M_WLO: begin
          m_cyc  = sat(m_cyc + 1);
          m_wait = m_wait + 1;
          if (!a) m_mode = M_RUN;
          else if (m_wait == TO) m_mode = M_ERR;
        end
        default: ;
      endcase
    end
  endtask

  // Monitor: compare the DUT against the queued prediction each cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("pc_en",       int'(pc_en),       int'(e.pc_en));
      chk("busy",        int'(busy),        int'(e.busy));
      chk("com_req",     int'(com_req),     int'(e.com_req));
      chk("done",        int'(done),        int'(e.done));
      chk("error",       int'(error),       int'(e.error));
      chk("instr_count", int'(instr_count), e.instr);
      chk("cycle_count", int'(cycle_count), e.cyc);
    end
  end

  logic [3:0] rid;
  int         rv;

  initial begin
    reset = 1'b1; start = 1'b0; Id = 4'd0; com_ack = 1'b0;

    // Reset state, then NOP,NOP,END with start held high and stray acks.
    cycle(0, 4'd0, 0, 1);
    cycle(0, 4'd0, 0, 1);
    cycle(1, 4'd0, 0, 0);
    cycle(1, 4'd0, 1, 0);
    cycle(1, 4'd0, 0, 0);
    cycle(1, 4'd2, 1, 0);
    for (int i = 0; i < 5; i++) cycle(1, 4'd0, i[0], 0);

    // COM with ack rising at k+3 and falling at k+5.
    cycle(0, 4'd0, 0, 1);
    cycle(1, 4'd0, 0, 0);
    cycle(0, 4'd7, 0, 0);
    cycle(0, 4'd1, 0, 0);   // k
    cycle(0, 4'd0, 0, 0);   // k+1
    cycle(0, 4'd0, 0, 0);   // k+2
    cycle(0, 4'd0, 1, 0);   // k+3
    cycle(0, 4'd0, 1, 0);   // k+4
    cycle(0, 4'd0, 0, 0);   // k+5
    cycle(0, 4'd0, 0, 0);   // k+6
    // Minimum two-cycle stall.
    cycle(0, 4'd1, 0, 0);
    cycle(0, 4'd0, 1, 0);
    cycle(0, 4'd0, 0, 0);
    cycle(0, 4'd2, 0, 0);
    cycle(0, 4'd0, 0, 0);

    // Reset in the middle of COM_REQ, then a fresh run.
    cycle(0, 4'd0, 0, 1);
    cycle(1, 4'd0, 0, 0);
    cycle(0, 4'd1, 0, 0);
    cycle(0, 4'd0, 0, 0);
    cycle(0, 4'd0, 0, 1);
    cycle(0, 4'd0, 0, 0);
    cycle(1, 4'd0, 0, 0);
    cycle(0, 4'd5, 0, 0);
    cycle(0, 4'd2, 0, 0);
    cycle(0, 4'd0, 0, 0);

    // Saturation: 20 NOPs.
    cycle(0, 4'd0, 0, 1);
    cycle(1, 4'd0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 4'd0, 0, 0);
    cycle(0, 4'd2, 0, 0);
    cycle(0, 4'd0, 0, 0);

    // Ack never rises: error after exactly TO cycles in COM_REQ.
    cycle(0, 4'd0, 0, 1);
    cycle(1, 4'd0, 0, 0);
    cycle(0, 4'd1, 0, 0);
    for (int i = 0; i < TO + 4; i++) cycle(0, 4'd0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(1, 4'd0, i[1], 0);

    // Ack never falls: error out of COM_REL.
    cycle(0, 4'd0, 0, 1);
    cycle(1, 4'd0, 0, 0);
    cycle(0, 4'd1, 0, 0);
    for (int i = 0; i < TO + 4; i++) cycle(0, 4'd0, 1, 0);

    // Randomized episodes.
    for (int ep = 0; ep < 30; ep++) begin
      cycle(0, 4'd0, 0, 1);
      for (int i = 0; i < 80; i++) begin
        rv = $urandom_range(0, 99);
        if (rv < 12)      rid = 4'd1;
        else if (rv < 16) rid = 4'd2;
        else if (rv < 30) rid = 4'd0;
        else              rid = 4'($urandom_range(3, 15));
        cycle(logic'($urandom_range(0, 1)), rid,
              logic'($urandom_range(0, 99) < 35),
              logic'($urandom_range(0, 99) < 2));
      end
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
